// File: rtl/wb_pkg.sv
// Shared widths and the beat record used by the writeback path and its load FIFO.
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic [XLEN-1:0]       data;
  } wb_beat_t;
endpackage

// File: rtl/writeback_unit_if.sv
// Producer-side handshake bundle: single-cycle ALU results and multi-cycle load results.
interface writeback_unit_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic [4:0]      alu_dst;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            mem_valid;
  logic [4:0]      mem_dst;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;

  modport master (
    output alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data,
    output alu_ready, mem_ready
  );
endinterface

// File: rtl/wb_fifo.sv
// Load-result buffer: power-of-two depth, wrapping pointers plus an occupancy count.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  wb_beat_t push_data,
  input  logic     pop,
  output wb_beat_t head,
  output logic     full,
  output logic     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_beat_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/writeback_unit.sv
// Serialises ALU and load results into one register-file write per cycle and tracks busy registers.
// Optional WB_BYPASS_EN adds a same-cycle forwarding path from the write port to decode.
module writeback_unit #(
  parameter int XLEN           = wb_pkg::XLEN,
  parameter int MEM_FIFO_DEPTH = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  writeback_unit_if.slave               bus,
  input  logic                          issue_valid,
  input  logic [wb_pkg::REG_ADDR_W-1:0] issue_dst,
  input  logic [wb_pkg::REG_ADDR_W-1:0] rs1,
  input  logic [wb_pkg::REG_ADDR_W-1:0] rs2,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic                          reg_write,
  output logic [wb_pkg::REG_ADDR_W-1:0] dst,
  output logic [XLEN-1:0]               wb
`ifdef WB_BYPASS_EN
  ,
  output logic                          rs1_byp,
  output logic                          rs2_byp,
  output logic [XLEN-1:0]               rs1_byp_data,
  output logic [XLEN-1:0]               rs2_byp_data
`endif
);
  import wb_pkg::wb_beat_t;
  import wb_pkg::REG_ADDR_W;
  import wb_pkg::NUM_REGS;

  wb_beat_t              fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  alu_take;
  logic                  win;
  logic [REG_ADDR_W-1:0] win_dst;
  logic [XLEN-1:0]       win_data;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  assign bus.mem_ready = !fifo_full;
  assign bus.alu_ready = !fifo_full;
  assign fifo_push     = bus.mem_valid && !fifo_full;

  // A full FIFO preempts the ALU so loads cannot starve indefinitely.
  assign alu_take = bus.alu_valid && !fifo_full;
  assign fifo_pop = !fifo_empty && (fifo_full || !bus.alu_valid);
  assign win      = alu_take || fifo_pop;
  assign win_dst  = alu_take ? bus.alu_dst  : fifo_head.dst;
  assign win_data = alu_take ? bus.alu_data : fifo_head.data;

  wb_fifo #(
    .DEPTH (MEM_FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst_n     (reset_n),
    .push      (fifo_push),
    .push_data ('{dst: bus.mem_dst, data: bus.mem_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      reg_write <= 1'b0;
      dst       <= '0;
      wb        <= '0;
    end else if (win) begin
      reg_write <= (win_dst != '0);
      dst       <= win_dst;
      wb        <= win_data;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // Clear on the retiring write first so a same-cycle issue to that register wins.
  always_comb begin
    busy_next = busy;
    if (reg_write)   busy_next[dst]       = 1'b0;
    if (issue_valid) busy_next[issue_dst] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_next;
  end

`ifdef WB_BYPASS_EN
  assign rs1_byp      = reg_write && (dst == rs1) && (rs1 != '0);
  assign rs2_byp      = reg_write && (dst == rs2) && (rs2 != '0);
  assign rs1_byp_data = wb;
  assign rs2_byp_data = wb;
  assign rs1_busy     = busy[rs1] && !rs1_byp;
  assign rs2_busy     = busy[rs2] && !rs2_byp;
`else
  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];
`endif
endmodule
